aes_ecb_dec_framer: RTL and testbench
=====================================

// Module: aes_ecb_dec_framer
// PURPOSE
//  Receive side of the AES-128-ECB channel: accepts a ciphertext byte stream and
//  frames it into 128-bit blocks. Each block goes to an external decrypt core over
//  a req/rsp handshake. Plaintext blocks are reassembled into one 256-bit message.
//  Sits between the byte-stream link and the decrypt core (RTL or pyvpi model).
// PARAMETERS
//  BLK_W     128  cipher block width (bits); fixed for AES-128
//  MSG_BLKS  2    blocks per output message (message = MSG_BLKS*BLK_W = 256 bits)
//  IN_W      8    input beat width; BLK_W % IN_W == 0
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  key_i          in   128      decrypt key; sampled with first beat of each message
//  in_valid_i     in   1        ciphertext beat valid
//  in_data_i      in   IN_W     ciphertext beat; first beat = MSBs of block
//  in_ready_o     out  1        framer can accept a beat
//  core_req_o     out  1        block request valid to decrypt core
//  core_key_o     out  128      latched message key
//  core_blk_o     out  BLK_W    ciphertext block
//  core_gnt_i     in   1        core accepted request (req & gnt = transfer)
//  core_rsp_i     in   1        core plaintext valid (single-cycle pulse)
//  core_pt_i      in   BLK_W    plaintext block
//  out_valid_o    out  1        message valid
//  out_data_o     out  MSG_BLKS*BLK_W  plaintext; block 0 in MSBs
//  out_ready_i    in   1        sink accepts message
//  err_o          out  1        sticky: core_rsp_i seen outside S_WAIT
//  flush_i        in   1        sync abort, discard partial message
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_FILL, beat_cnt=0, blk_cnt=0.
//   All outputs 0 except in_ready_o=1; data regs cleared.
//  FSM:
//   S_FILL: in_ready_o=1. Each in_valid_i beat shifts into blk_sr (left shift, new beat in LSBs), beat_cnt++.
//           Beat with beat_cnt==0 && blk_cnt==0 also latches key_i.
//           On beat BLK_W/IN_W-1: beat_cnt->0, go S_REQ.
//   S_REQ:  core_req_o=1, core_blk_o=blk_sr, core_key_o=key_q, both stable until gnt.
//           On core_gnt_i go S_WAIT (gnt same cycle as req entry allowed).
//   S_WAIT: on core_rsp_i write core_pt_i to slot blk_cnt (slot 0 = MSBs).
//           If blk_cnt==MSG_BLKS-1 go S_OUT, else blk_cnt++ and go S_FILL.
//   S_OUT:  out_valid_o=1, out_data_o stable. On out_ready_i: blk_cnt=0, go S_FILL.
//  Latency: core_req_o rises the cycle after the 16th beat is accepted.
//   out_valid_o rises the cycle after the last core_rsp_i.
//  in_ready_o=0 in S_REQ/S_WAIT/S_OUT (no overlap; one block in flight max).
//  Byte counter wraps exactly at BLK_W/IN_W; no partial-block flush on idle.
//  core_rsp_i in any state other than S_WAIT: ignored, err_o set (cleared only by reset).
//  flush_i: highest priority, any state. Next cycle S_FILL, counters 0, core_req_o=0.
//   A core_rsp_i still owed to a flushed request is dropped; err_o is not set for it.
//  key_i changes mid-message have no effect until the next message's first beat.
//  Mid-operation reset: immediate return to reset values, no output glitch to valid.
// STRUCTURE
//  Package aes_ecb_pkg: BLK_W/KEY_W localparams, typedef logic [127:0] aes_blk_t,
//   aes_key_t, and state enum {S_FILL,S_REQ,S_WAIT,S_OUT}; shared with the encrypt-side framer.
//  One sub-module: aes_blk_deser (IN_W->BLK_W shift register + beat counter, done pulse).
//  Top holds FSM, key latch, message buffer, err flag.
// TESTING  (bench uses a behavioural AES-128 decrypt core, 3-cycle rsp)
//  1 key 2b7e151628aed2a6abf7158809cf4f3c, bytes 3ad77bb4..2466ef97 then f5d3d585..96fdbaaf
//    -> out_data 6bc1bee22e409f96e93d7e117393172a_ae2d8a571e03ac9c9eb76fac45af8e51.
//  2 same stream, out_ready_i low 20 cycles -> out_valid_o/out_data_o held; in_ready_o=0 meanwhile.
//  3 core_gnt_i delayed 5 cycles -> core_req_o/core_blk_o stable; one request per block.
//  4 flush_i after 9 bytes of block 1 -> no req issued; next full 32 bytes give the test-1 result.
//  5 core_rsp_i pulse while in S_FILL -> err_o=1 sticky, framing unaffected.
//  6 rst_n low in S_WAIT -> outputs at reset values; next message decodes correctly.

Source files
------------

// File: rtl/aes_ecb_pkg.sv
// Shared AES-128-ECB framer definitions (block/key types, framer FSM states).
// Used by both the decrypt-side and encrypt-side framers.
package aes_ecb_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 128;

  typedef logic [BLK_W-1:0] aes_blk_t;
  typedef logic [KEY_W-1:0] aes_key_t;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  // Number of input beats needed to build one cipher block.
  function automatic int beats_per_blk(input int blk_w, input int in_w);
    return blk_w / in_w;
  endfunction

endpackage

// File: rtl/aes_blk_deser.sv
// Beat-to-block deserializer: shifts IN_W beats MSB-first into a BLK_W word.
// done_o marks the beat that completes a block; the counter wraps on that beat.
module aes_blk_deser
#(
  parameter int BLK_W = 128,
  parameter int IN_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [BLK_W-1:0] blk_o,
  output logic             first_o,
  output logic             done_o
);
  import aes_ecb_pkg::*;

  localparam int BEATS = beats_per_blk(BLK_W, IN_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (en_i) begin
      sr_d  = (sr_q << IN_W) | BLK_W'(data_i);
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign blk_o   = sr_q;
  assign first_o = (cnt_q == '0);
  assign done_o  = en_i && !clr_i && (cnt_q == LAST_BEAT);

endmodule

// File: rtl/aes_ecb_dec_framer.sv
// AES-128-ECB receive framer: frames ciphertext beats into blocks, passes each to an
// external decrypt core over req/gnt, and reassembles plaintext into one message.
module aes_ecb_dec_framer
#(
  parameter int BLK_W    = aes_ecb_pkg::BLK_W,
  parameter int MSG_BLKS = 2,
  parameter int IN_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [127:0]              key_i,
  input  logic                      in_valid_i,
  input  logic [IN_W-1:0]           in_data_i,
  output logic                      in_ready_o,
  output logic                      core_req_o,
  output logic [127:0]              core_key_o,
  output logic [BLK_W-1:0]          core_blk_o,
  input  logic                      core_gnt_i,
  input  logic                      core_rsp_i,
  input  logic [BLK_W-1:0]          core_pt_i,
  output logic                      out_valid_o,
  output logic [MSG_BLKS*BLK_W-1:0] out_data_o,
  input  logic                      out_ready_i,
  output logic                      err_o,
  input  logic                      flush_i
);
  import aes_ecb_pkg::*;

  localparam int BC_W = (MSG_BLKS > 1) ? $clog2(MSG_BLKS) : 1;
  localparam logic [BC_W-1:0] LAST_BLK = BC_W'(MSG_BLKS - 1);

  state_e           state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [BC_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic [BLK_W-1:0] msg_q [MSG_BLKS];
  logic             err_q, err_d;
  logic             owed_q, owed_d;

  logic             beat_acc, beat_first, blk_done;
  logic [BLK_W-1:0] blk_sr;
  logic             rsp_take, rsp_drop, rsp_stray;

  assign beat_acc = in_valid_i && in_ready_o && !flush_i;

  aes_blk_deser #(
    .BLK_W (BLK_W),
    .IN_W  (IN_W)
  ) u_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_i),
    .en_i    (beat_acc),
    .data_i  (in_data_i),
    .blk_o   (blk_sr),
    .first_o (beat_first),
    .done_o  (blk_done)
  );

  // owed_q: a request was handed to the core and then flushed, so its response is stale.
  assign rsp_drop  = core_rsp_i && owed_q;
  assign rsp_take  = core_rsp_i && !owed_q && (state_q == S_WAIT) && !flush_i;
  assign rsp_stray = core_rsp_i && !owed_q && (state_q != S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_FILL;
    end else begin
      unique case (state_q)
        S_FILL: if (blk_done) state_d = S_REQ;
        S_REQ:  if (core_gnt_i) state_d = S_WAIT;
        S_WAIT: if (rsp_take) state_d = (blk_cnt_q == LAST_BLK) ? S_OUT : S_FILL;
        S_OUT:  if (out_ready_i) state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = 1'b0;
    core_req_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      S_FILL:  in_ready_o  = 1'b1;
      S_REQ:   core_req_o  = 1'b1;
      S_OUT:   out_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    key_d     = key_q;
    blk_cnt_d = blk_cnt_q;
    err_d     = err_q | rsp_stray;
    owed_d    = owed_q;

    // The message key is taken only from the very first beat of a message.
    if (beat_acc && beat_first && (blk_cnt_q == '0)) begin
      key_d = key_i;
    end

    if (flush_i) begin
      blk_cnt_d = '0;
    end else if (rsp_take && (blk_cnt_q != LAST_BLK)) begin
      blk_cnt_d = blk_cnt_q + BC_W'(1);
    end else if ((state_q == S_OUT) && out_ready_i) begin
      blk_cnt_d = '0;
    end

    if (rsp_drop) begin
      owed_d = 1'b0;
    end
    if (flush_i && (((state_q == S_WAIT) && !(core_rsp_i && !owed_q)) ||
                    ((state_q == S_REQ) && core_gnt_i))) begin
      owed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      blk_cnt_q <= '0;
      err_q     <= 1'b0;
      owed_q    <= 1'b0;
    end else begin
      key_q     <= key_d;
      blk_cnt_q <= blk_cnt_d;
      err_q     <= err_d;
      owed_q    <= owed_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_BLKS; i++) begin
        msg_q[i] <= '0;
      end
    end else if (rsp_take) begin
      msg_q[blk_cnt_q] <= core_pt_i;
    end
  end

  // Slot 0 occupies the most significant block of the message.
  for (genvar gi = 0; gi < MSG_BLKS; gi++) begin : g_slot
    assign out_data_o[(MSG_BLKS-1-gi)*BLK_W +: BLK_W] = msg_q[gi];
  end

  assign core_key_o = key_q;
  assign core_blk_o = blk_sr;
  assign err_o      = err_q;

endmodule

// File: tb/tb_aes_ecb_dec_framer.sv
// Self-checking bench for aes_ecb_dec_framer with a behavioural AES-128 decrypt core
// (3-cycle response) and a reference model computing expected messages from the stream.
module tb_aes_ecb_dec_framer;

  localparam int RSP_LAT = 3;
  localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KAT_CT0 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] KAT_CT1 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [255:0] KAT_PT  =
    256'h6bc1bee22e409f96e93d7e117393172a_ae2d8a571e03ac9c9eb76fac45af8e51;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_i;
  logic         in_valid_i;
  logic [7:0]   in_data_i;
  logic         in_ready_o;
  logic         core_req_o;
  logic [127:0] core_key_o;
  logic [127:0] core_blk_o;
  logic         core_gnt_i;
  logic         core_rsp_i;
  logic [127:0] core_pt_i;
  logic         out_valid_o;
  logic [255:0] out_data_o;
  logic         out_ready_i;
  logic         err_o;
  logic         flush_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // core model state
  int           gnt_delay = 0;
  int           gap_max = 0;
  int           rsp_cnt = -1;
  int           req_age = 0;
  int           n_xfer = 0;
  int           last_rsp_cyc = 0;
  logic         req_prev = 1'b0;
  bit           inject_rsp = 1'b0;
  logic [127:0] cap_blk, cap_key, pend_pt;

  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];

  aes_ecb_dec_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_i       (key_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .core_req_o  (core_req_o),
    .core_key_o  (core_key_o),
    .core_blk_o  (core_blk_o),
    .core_gnt_i  (core_gnt_i),
    .core_rsp_i  (core_rsp_i),
    .core_pt_i   (core_pt_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .err_o       (err_o),
    .flush_i     (flush_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256 && a != 0; b++) begin
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_sbox[sbox[a]] = 8'(a);
  endtask

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [127:0] rk [11];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] blk;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    blk = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      // state byte (row q, column c) is at index q + 4*c
      for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[q+4*c] = inv_sbox[s[q + 4*((c - q + 4) % 4)]];
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      blk = blk ^ rk[r];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gm(s[4*c], 8'd14) ^ gm(s[4*c+1], 8'd11) ^ gm(s[4*c+2], 8'd13) ^ gm(s[4*c+3], 8'd9);
          t[4*c+1] = gm(s[4*c], 8'd9)  ^ gm(s[4*c+1], 8'd14) ^ gm(s[4*c+2], 8'd11) ^ gm(s[4*c+3], 8'd13);
          t[4*c+2] = gm(s[4*c], 8'd13) ^ gm(s[4*c+1], 8'd9)  ^ gm(s[4*c+2], 8'd14) ^ gm(s[4*c+3], 8'd11);
          t[4*c+3] = gm(s[4*c], 8'd11) ^ gm(s[4*c+1], 8'd13) ^ gm(s[4*c+2], 8'd9)  ^ gm(s[4*c+3], 8'd14);
        end
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      end
    end
    return blk;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- decrypt core model ----------------
  initial begin
    core_gnt_i = 1'b0;
    core_rsp_i = 1'b0;
    core_pt_i  = '0;
    forever begin
      @(negedge clk);
      core_rsp_i = 1'b0;
      if (!rst_n) begin
        rsp_cnt    = -1;
        req_age    = 0;
        core_gnt_i = 1'b0;
        req_prev   = 1'b0;
      end else begin
        if (rsp_cnt == 0) begin
          core_rsp_i   = 1'b1;
          core_pt_i    = pend_pt;
          rsp_cnt      = -1;
          last_rsp_cyc = cyc + 1;
        end else if (rsp_cnt > 0) begin
          rsp_cnt--;
        end
        if (inject_rsp) begin
          core_rsp_i = 1'b1;
          core_pt_i  = rnd128();
          inject_rsp = 1'b0;
        end
        if (core_gnt_i && req_prev) begin
          pend_pt = aes_dec(cap_key, cap_blk);
          rsp_cnt = RSP_LAT - 2;
          n_xfer++;
        end
        if (core_req_o) begin
          if (req_age > 0) begin
            checks++;
            if (core_blk_o !== cap_blk || core_key_o !== cap_key) begin
              errors++;
              $display("FAIL req_stable blk %h key %h required blk %h key %h",
                       core_blk_o, core_key_o, cap_blk, cap_key);
            end
          end
          cap_blk    = core_blk_o;
          cap_key    = core_key_o;
          core_gnt_i = (req_age >= gnt_delay);
          req_age++;
        end else begin
          core_gnt_i = 1'b0;
          req_age    = 0;
        end
        req_prev = core_req_o;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input logic [7:0] b, input logic [127:0] k);
    int t;
    @(negedge clk);
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = b;
    key_i      = k;
    t = 0;
    while (in_ready_o !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout in_ready_o %0b required 1", in_ready_o);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    key_i      = rnd128();
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] k0,
                            input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      send_beat(ct[127-8*i -: 8], (i == 0) ? k0 : rnd128());
    end
    if (hi == 16) begin
      checks++;
      if (core_req_o !== 1'b1) begin
        errors++;
        $display("FAIL req_latency core_req_o %0b required 1", core_req_o);
      end
    end
  endtask

  task automatic send_msg(input logic [127:0] ct0, input logic [127:0] ct1,
                          input logic [127:0] k);
    send_block(ct0, k, 0, 16);
    send_block(ct1, rnd128(), 0, 16);
  endtask

  task automatic wait_out(input logic [255:0] exp, input int hold, input string name);
    int t = 0;
    @(negedge clk);
    while (out_valid_o !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 400) begin
      errors++;
      $display("FAIL %s out_timeout out_valid_o %0b required 1", name, out_valid_o);
      return;
    end
    checks++;
    if (cyc != last_rsp_cyc) begin
      errors++;
      $display("FAIL %s out_latency valid at cycle %0d required %0d", name, cyc, last_rsp_cyc);
    end
    checks++;
    if (out_data_o !== exp) begin
      errors++;
      $display("FAIL %s out_data %h required %h", name, out_data_o, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp || in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s hold valid %0b ready %0b data %h required 1 0 %h",
                 name, out_valid_o, in_ready_o, out_data_o, exp);
      end
    end
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s release valid %0b ready %0b required 0 1", name, out_valid_o, in_ready_o);
    end
    $display("msg %s done data %h", name, out_data_o);
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name, input logic exp_err);
    checks++;
    if ({in_ready_o, core_req_o, out_valid_o, err_o} !== {3'b100, exp_err}) begin
      errors++;
      $display("FAIL %s ctrl rdy/req/val/err %b required %b", name,
               {in_ready_o, core_req_o, out_valid_o, err_o}, {3'b100, exp_err});
    end
  endtask

  task automatic wait_xfer(input int base);
    int t = 0;
    while (n_xfer == base && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 100) begin
      errors++;
      $display("FAIL xfer_timeout transfers %0d required %0d", n_xfer, base + 1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b0);
    checks++;
    if (out_data_o !== '0 || core_blk_o !== '0 || core_key_o !== '0) begin
      errors++;
      $display("FAIL reset_data out %h blk %h key %h required 0", out_data_o, core_blk_o, core_key_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset", 1'b0);
  endtask

  task automatic test_kat();
    int x0 = n_xfer;
    send_msg(KAT_CT0, KAT_CT1, KAT_KEY);
    wait_out(KAT_PT, 0, "kat");
    checks++;
    if (n_xfer - x0 != 2) begin
      errors++;
      $display("FAIL kat_xfers %0d required 2", n_xfer - x0);
    end
  endtask

  task automatic test_backpressure();
    send_msg(KAT_CT0, KAT_CT1, KAT_KEY);
    wait_out(KAT_PT, 20, "hold");
  endtask

  task automatic test_gnt_delay();
    int x0 = n_xfer;
    gnt_delay = 5;
    send_msg(KAT_CT0, KAT_CT1, KAT_KEY);
    wait_out(KAT_PT, 0, "gnt_delay");
    checks++;
    if (n_xfer - x0 != 2) begin
      errors++;
      $display("FAIL gnt_delay_xfers %0d required 2", n_xfer - x0);
    end
    gnt_delay = 0;
  endtask

  task automatic test_flush();
    int x0;
    // partial first block
    x0 = n_xfer;
    send_block(rnd128(), rnd128(), 0, 9);
    do_flush();
    check_idle_outputs("flush_fill", 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (n_xfer != x0 || core_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_req transfers %0d req %0b required %0d 0", n_xfer, core_req_o, x0);
    end
    send_msg(KAT_CT0, KAT_CT1, KAT_KEY);
    wait_out(KAT_PT, 0, "flush_a");
    // full first block plus 9 beats of the second
    send_block(rnd128(), rnd128(), 0, 16);
    send_block(rnd128(), rnd128(), 0, 9);
    do_flush();
    check_idle_outputs("flush_blk1", 1'b0);
    send_msg(KAT_CT0, KAT_CT1, KAT_KEY);
    wait_out(KAT_PT, 0, "flush_b");
    // flush while the core still owes a response
    x0 = n_xfer;
    send_block(rnd128(), rnd128(), 0, 16);
    wait_xfer(x0);
    do_flush();
    repeat (6) @(negedge clk);
    check_idle_outputs("flush_wait", 1'b0);
    send_msg(KAT_CT0, KAT_CT1, KAT_KEY);
    wait_out(KAT_PT, 0, "flush_c");
    check_idle_outputs("flush_c_err", 1'b0);
  endtask

  task automatic test_stray_rsp();
    send_block(KAT_CT0, KAT_KEY, 0, 5);
    inject_rsp = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL stray_err err_o %0b required 1", err_o);
    end
    send_block(KAT_CT0, KAT_KEY, 5, 16);
    send_block(KAT_CT1, rnd128(), 0, 16);
    wait_out(KAT_PT, 0, "stray");
    check_idle_outputs("stray_sticky", 1'b1);
  endtask

  task automatic test_mid_reset();
    int x0 = n_xfer;
    send_block(rnd128(), rnd128(), 0, 16);
    wait_xfer(x0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset", 1'b0);
    checks++;
    if (out_data_o !== '0 || core_blk_o !== '0 || core_key_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_data out %h blk %h key %h required 0", out_data_o, core_blk_o, core_key_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_msg(KAT_CT0, KAT_CT1, KAT_KEY);
    wait_out(KAT_PT, 0, "after_reset");
    check_idle_outputs("after_reset_err", 1'b0);
  endtask

  task automatic test_random();
    logic [127:0] k, c0, c1;
    for (int n = 0; n < 6; n++) begin
      k  = rnd128();
      c0 = rnd128();
      c1 = rnd128();
      gnt_delay = $urandom_range(4, 0);
      gap_max   = $urandom_range(2, 0);
      send_msg(c0, c1, k);
      wait_out({aes_dec(k, c0), aes_dec(k, c1)}, $urandom_range(3, 0), "random");
    end
    gnt_delay = 0;
    gap_max   = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    key_i       = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    build_sbox();
    test_reset();
    test_kat();
    test_backpressure();
    test_gnt_delay();
    test_flush();
    test_stray_rsp();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
